// File: rtl/umtrx_stream_scheduler.sv
// Packet-granular arbiter: eight requester streams share one outbound stream,
// one whole packet per grant, two priority classes with separate round-robin pointers.

module umtrx_sched_lane #(
  parameter int IDX = 0
) (
  input  logic [2:0] grant,
  input  logic       live,
  input  logic       out_ready,
  input  logic       valid,
  input  logic       en,
  input  logic       hipri,
  input  logic       freeze,
  output logic       ready,
  output logic       req_hi,
  output logic       req_lo
);
  logic req;
  assign req    = valid & en & ~freeze;
  assign req_hi = req & hipri;
  assign req_lo = req & ~hipri;
  assign ready  = live & out_ready & (grant == 3'(IDX));
endmodule

module umtrx_stream_scheduler #(
  parameter int BASE  = 0,
  parameter int WIDTH = 36,
  parameter int PORTS = 8
) (
  input  logic                   stream_clk,
  input  logic                   stream_rst_n,
  input  logic                   stream_clr,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic [PORTS*WIDTH-1:0] inp_data,
  input  logic [PORTS-1:0]       inp_valid,
  output logic [PORTS-1:0]       inp_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            status
);
  localparam logic [7:0] ADDR_MASK = 8'(BASE);
  localparam logic [7:0] ADDR_CTRL = 8'(BASE + 1);
  localparam int         EOF_BIT   = 33;

  typedef enum logic {IDLE, PASS} state_t;

  state_t                        state;
  logic [2:0]                    grant, hi_ptr, lo_ptr;
  logic                          grant_hi;
  logic [15:0]                   pkt_count;
  logic [PORTS-1:0]              enable_mask, hipri_mask;
  logic                          freeze;
  logic [PORTS-1:0]              req_hi, req_lo;
  logic [PORTS-1:0][WIDTH-1:0]   in_words;
  logic                          live, xfer, eof;
  logic                          unused;

  assign in_words = inp_data;
  assign unused   = ^set_data[31:16];

  // Reset and clear drop the path combinationally so an aborted packet stops at once.
  assign live      = (state == PASS) & stream_rst_n & ~stream_clr;
  assign out_data  = live ? in_words[grant] : '0;
  assign out_valid = live & inp_valid[grant];
  assign xfer      = out_valid & out_ready;
  assign eof       = out_data[EOF_BIT];
  assign status    = {pkt_count, 4'b0, state == PASS, grant, enable_mask};

  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    umtrx_sched_lane #(.IDX(i)) u_lane (
      .grant     (grant),
      .live      (live),
      .out_ready (out_ready),
      .valid     (inp_valid[i]),
      .en        (enable_mask[i]),
      .hipri     (hipri_mask[i]),
      .freeze    (freeze),
      .ready     (inp_ready[i]),
      .req_hi    (req_hi[i]),
      .req_lo    (req_lo[i])
    );
  end

  // First set bit at or after ptr, cyclically; the downward loop lets the nearest win.
  function automatic logic [2:0] rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (vec[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge stream_clk) begin
    if (!stream_rst_n) begin
      enable_mask <= '1;
      hipri_mask  <= '0;
      freeze      <= 1'b0;
    end else if (set_stb) begin
      if (set_addr == ADDR_MASK) {hipri_mask, enable_mask} <= set_data[15:0];
      if (set_addr == ADDR_CTRL) freeze <= set_data[0];
    end
  end

  always_ff @(posedge stream_clk) begin
    if (!stream_rst_n || stream_clr) begin
      state     <= IDLE;
      grant     <= '0;
      grant_hi  <= 1'b0;
      hi_ptr    <= '0;
      lo_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_hi) begin
            grant    <= rr_pick(req_hi, hi_ptr);
            grant_hi <= 1'b1;
            state    <= PASS;
          end else if (|req_lo) begin
            grant    <= rr_pick(req_lo, lo_ptr);
            grant_hi <= 1'b0;
            state    <= PASS;
          end
        end
        PASS: begin
          if (xfer && eof) begin
            state     <= IDLE;
            pkt_count <= pkt_count + 16'd1;
            // Class was latched at grant time, so a mid-packet mask change cannot move the other pointer.
            if (grant_hi) hi_ptr <= grant + 3'd1;
            else          lo_ptr <= grant + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
